// File: rtl/mest_pro_seq_pkg.sv
// Shared types and constants for the MESTPro instruction sequencer.
package mest_pro_seq_pkg;

    // Legacy state encodings, kept so existing tooling and traces decode unchanged.
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXECUTE = 3'd3;
    localparam logic [2:0] S_PAUSE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_FAULT   = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_FETCH   = S_FETCH,
        ST_DECODE  = S_DECODE,
        ST_EXECUTE = S_EXECUTE,
        ST_PAUSE   = S_PAUSE,
        ST_DONE    = S_DONE,
        ST_FAULT   = S_FAULT
    } seq_state_t;

    // Fault codes reported on o_fault_code.
    localparam logic [1:0] FLT_MEM = 2'd0;
    localparam logic [1:0] FLT_TMO = 2'd1;
    localparam logic [1:0] FLT_OVF = 2'd2;
    localparam logic [1:0] FLT_UNF = 2'd3;

endpackage

// File: rtl/mest_pro_call_stack.sv
// Hardware LIFO holding return addresses for call/return.
// Push at full and pop at empty are silently ignored; the caller decides
// whether that is a fault.
module mest_pro_call_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LVL_W-1:0] lvl;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign wr_idx   = lvl[IDX_W-1:0];
    assign rd_idx   = IDX_W'(lvl - LVL_W'(1));
    assign pop_data = mem[rd_idx];
    assign full     = (lvl == LVL_W'(DEPTH));
    assign empty    = (lvl == '0);
    assign level    = lvl;

    // Stack pointer and storage update; push wins if both are requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl <= '0;
        end else if (push && !full) begin
            mem[wr_idx] <= push_data;
            lvl         <= lvl + LVL_W'(1);
        end else if (pop && !empty) begin
            lvl <= lvl - LVL_W'(1);
        end
    end

endmodule

// File: rtl/mest_pro_sequencer.sv
// MESTPro instruction sequencer: PC, fetch handshake with wait-state
// timeout, call/return stack and single-step debug pause.
module mest_pro_sequencer #(
    parameter int unsigned PC_WIDTH    = 16,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned WAIT_LIMIT  = 15
) (
    input  logic                               clk,
    input  logic                               i_reset,
    input  logic                               i_start,
    input  logic                               i_step_mode,
    input  logic                               i_step,
    output logic                               o_req,
    output logic [PC_WIDTH-1:0]                o_prog_counter,
    input  logic                               i_ack,
    input  logic [INSTR_WIDTH-1:0]             i_instruction,
    input  logic                               i_mem_error,
    output logic [INSTR_WIDTH-1:0]             o_decode_reg,
    input  logic                               i_exec_done,
    input  logic                               i_end_of_code,
    input  logic                               i_jump,
    input  logic                               i_call,
    input  logic                               i_return,
    input  logic [PC_WIDTH-1:0]                i_target,
    output logic                               o_idle,
    output logic                               o_fetch,
    output logic                               o_decode,
    output logic                               o_execute,
    output logic                               o_pause,
    output logic                               o_all_done,
    output logic                               o_fault,
    output logic [1:0]                         o_fault_code,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   o_stack_level
);

    import mest_pro_seq_pkg::*;

    localparam int unsigned LVL_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned WAIT_W = $clog2(WAIT_LIMIT + 1);

    seq_state_t             state;
    seq_state_t             run_next;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pc_inc;
    logic [PC_WIDTH-1:0]    stack_top;
    logic [WAIT_W-1:0]      wait_cnt;
    logic [INSTR_WIDTH-1:0] decode_reg;
    logic [1:0]             fault_code;
    logic                   stack_push;
    logic                   stack_pop;
    logic                   stack_full;
    logic                   stack_empty;
    logic [LVL_W-1:0]       stack_level;

    // Modulo-2**PC_WIDTH increment; wrap from all-ones to zero is intended.
    assign pc_inc   = pc + PC_WIDTH'(1);
    assign run_next = i_step_mode ? ST_PAUSE : ST_FETCH;

    // Stack requests only for a retiring call/return not pre-empted by end_of_code.
    always_comb begin
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        if (state == ST_EXECUTE && i_exec_done && !i_end_of_code) begin
            if (i_return) begin
                stack_pop = !stack_empty;
            end else if (i_call) begin
                stack_push = !stack_full;
            end
        end
    end

    mest_pro_call_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_WIDTH)
    ) u_call_stack (
        .clk       (clk),
        .reset     (i_reset),
        .push      (stack_push),
        .pop       (stack_pop),
        .push_data (pc_inc),
        .pop_data  (stack_top),
        .full      (stack_full),
        .empty     (stack_empty),
        .level     (stack_level)
    );

    // Main FSM: fetch handshake, next-PC resolution and terminal states.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            pc         <= '0;
            wait_cnt   <= '0;
            decode_reg <= '0;
            fault_code <= '0;
        end else begin
            // Counter only advances inside FETCH, so every FETCH entry starts at zero.
            wait_cnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (i_mem_error) begin
                        state      <= ST_FAULT;
                        fault_code <= FLT_MEM;
                    end else if (i_ack) begin
                        decode_reg <= i_instruction;
                        state      <= ST_DECODE;
                    end else if (wait_cnt == WAIT_W'(WAIT_LIMIT - 1)) begin
                        state      <= ST_FAULT;
                        fault_code <= FLT_TMO;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_DECODE: begin
                    state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (i_exec_done) begin
                        if (i_end_of_code) begin
                            state <= ST_DONE;
                        end else if (i_return) begin
                            if (stack_empty) begin
                                state      <= ST_FAULT;
                                fault_code <= FLT_UNF;
                            end else begin
                                pc    <= stack_top;
                                state <= run_next;
                            end
                        end else if (i_call) begin
                            if (stack_full) begin
                                state      <= ST_FAULT;
                                fault_code <= FLT_OVF;
                            end else begin
                                pc    <= i_target;
                                state <= run_next;
                            end
                        end else if (i_jump) begin
                            pc    <= i_target;
                            state <= run_next;
                        end else begin
                            pc    <= pc_inc;
                            state <= run_next;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (i_step || !i_step_mode) begin
                        state <= ST_FETCH;
                    end
                end
                ST_DONE, ST_FAULT: begin
                    state <= state;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req          = (state == ST_FETCH);
    assign o_prog_counter = pc;
    assign o_decode_reg   = decode_reg;
    assign o_idle         = (state == ST_IDLE);
    assign o_fetch        = (state == ST_FETCH);
    assign o_decode       = (state == ST_DECODE);
    assign o_execute      = (state == ST_EXECUTE);
    assign o_pause        = (state == ST_PAUSE);
    assign o_all_done     = (state == ST_DONE);
    assign o_fault        = (state == ST_FAULT);
    assign o_fault_code   = fault_code;
    assign o_stack_level  = stack_level;

endmodule

// File: tb/tb_mest_pro_sequencer.sv
// Self-checking bench for mest_pro_sequencer: the bench plays program memory
// and execute unit, and predicts PC, stack depth and faults from a
// transaction-level model (queue for the call stack, plain PC arithmetic).
module tb_mest_pro_sequencer;

    localparam int PCW = 16;
    localparam int IW  = 32;
    localparam int SD  = 8;
    localparam int WL  = 15;

    localparam logic [4:0] FL_NONE  = 5'b00000;
    localparam logic [4:0] FL_IDLE  = 5'b10000;
    localparam logic [4:0] FL_FETCH = 5'b01000;
    localparam logic [4:0] FL_DEC   = 5'b00100;
    localparam logic [4:0] FL_EXEC  = 5'b00010;
    localparam logic [4:0] FL_PAUSE = 5'b00001;

    logic           clk = 1'b0;
    logic           i_reset, i_start, i_step_mode, i_step;
    logic           o_req;
    logic [PCW-1:0] o_prog_counter;
    logic           i_ack;
    logic [IW-1:0]  i_instruction;
    logic           i_mem_error;
    logic [IW-1:0]  o_decode_reg;
    logic           i_exec_done, i_end_of_code, i_jump, i_call, i_return;
    logic [PCW-1:0] i_target;
    logic           o_idle, o_fetch, o_decode, o_execute, o_pause;
    logic           o_all_done, o_fault;
    logic [1:0]     o_fault_code;
    logic [3:0]     o_stack_level;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model state
    logic [PCW-1:0] m_pc;
    logic [PCW-1:0] m_stack [$];
    logic [1:0]     m_code;
    bit             step_mode;

    always #5 clk = ~clk;

    mest_pro_sequencer #(
        .PC_WIDTH    (PCW),
        .INSTR_WIDTH (IW),
        .STACK_DEPTH (SD),
        .WAIT_LIMIT  (WL)
    ) dut (
        .clk            (clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_step_mode    (i_step_mode),
        .i_step         (i_step),
        .o_req          (o_req),
        .o_prog_counter (o_prog_counter),
        .i_ack          (i_ack),
        .i_instruction  (i_instruction),
        .i_mem_error    (i_mem_error),
        .o_decode_reg   (o_decode_reg),
        .i_exec_done    (i_exec_done),
        .i_end_of_code  (i_end_of_code),
        .i_jump         (i_jump),
        .i_call         (i_call),
        .i_return       (i_return),
        .i_target       (i_target),
        .o_idle         (o_idle),
        .o_fetch        (o_fetch),
        .o_decode       (o_decode),
        .o_execute      (o_execute),
        .o_pause        (o_pause),
        .o_all_done     (o_all_done),
        .o_fault        (o_fault),
        .o_fault_code   (o_fault_code),
        .o_stack_level  (o_stack_level)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, o_idle, o_fetch, o_decode, o_execute, o_pause}, {27'd0, exp});
    endtask

    task automatic clear_inputs();
        i_start = 0; i_step = 0; i_ack = 0; i_instruction = '0; i_mem_error = 0;
        i_exec_done = 0; i_end_of_code = 0; i_jump = 0; i_call = 0; i_return = 0;
        i_target = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        step_mode = 0; i_step_mode = 0;
        i_reset = 1;
        @(negedge clk);
        @(negedge clk);
        chk_flags("reset_flags", FL_IDLE);
        chk("reset_req", o_req, 0);
        chk("reset_pc", o_prog_counter, 0);
        chk("reset_dreg", o_decode_reg, 0);
        chk("reset_fault", {o_fault, o_fault_code, o_all_done}, 0);
        chk("reset_level", o_stack_level, 0);
        i_reset = 0;
        @(negedge clk);
        chk_flags("idle_hold", FL_IDLE);
        m_pc = '0;
        m_stack.delete();
        m_code = '0;
    endtask

    task automatic start_seq();
        chk_flags("pre_start", FL_IDLE);
        i_start = 1;
        @(negedge clk);
        i_start = 0;
        chk_flags("start_fetch", FL_FETCH);
    endtask

    // One instruction from FETCH entry to the next FETCH (or a terminal state).
    // status: 0 = running, 1 = done, 2 = fault
    task automatic run_instr(input int waits, input bit err, input int dur,
                             input bit eoc, input bit ret, input bit call, input bit jmp,
                             input logic [PCW-1:0] tgt, output int status);
        logic [IW-1:0] word;
        bit timeout;
        int n_req;
        status  = 0;
        word    = $urandom;
        timeout = (waits >= WL);
        n_req   = timeout ? WL : waits + 1;
        for (int c = 0; c < n_req; c++) begin
            chk("fetch_req", o_req, 1);
            chk("fetch_pc", o_prog_counter, m_pc);
            if (c == waits) begin
                i_ack = 1; i_instruction = word; i_mem_error = err;
            end else begin
                i_ack = 0; i_instruction = $urandom; i_mem_error = 0;
            end
            @(negedge clk);
        end
        i_ack = 0; i_mem_error = 0;
        if (timeout || err) begin
            m_code = timeout ? 2'd1 : 2'd0;
            chk("fetch_fault", o_fault, 1);
            chk("fetch_fault_code", o_fault_code, m_code);
            chk("fault_req", o_req, 0);
            chk_flags("fault_flags", FL_NONE);
            status = 2;
            return;
        end
        chk_flags("decode_flags", FL_DEC);
        chk("decode_req", o_req, 0);
        chk("decode_reg", o_decode_reg, word);
        @(negedge clk);
        chk_flags("exec_flags", FL_EXEC);
        for (int j = 0; j < dur; j++) begin
            i_step = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            i_step = 0;
            chk_flags("exec_hold", FL_EXEC);
        end
        i_exec_done = 1; i_end_of_code = eoc; i_return = ret; i_call = call;
        i_jump = jmp; i_target = tgt;
        @(negedge clk);
        i_exec_done = 0; i_end_of_code = 0; i_return = 0; i_call = 0; i_jump = 0;
        i_target = '0;
        if (eoc) begin
            chk("done", o_all_done, 1);
            chk_flags("done_flags", FL_NONE);
            chk("done_pc", o_prog_counter, m_pc);
            status = 1;
        end else if (ret) begin
            if (m_stack.size() == 0) begin
                m_code = 2'd3; status = 2;
            end else begin
                m_pc = m_stack.pop_back();
            end
        end else if (call) begin
            if (m_stack.size() == SD) begin
                m_code = 2'd2; status = 2;
            end else begin
                m_stack.push_back(m_pc + 16'd1);
                m_pc = tgt;
            end
        end else if (jmp) begin
            m_pc = tgt;
        end else begin
            m_pc = m_pc + 16'd1;
        end
        chk("stack_level", o_stack_level, m_stack.size());
        if (status == 2) begin
            chk("stack_fault", o_fault, 1);
            chk("stack_fault_code", o_fault_code, m_code);
            chk_flags("fault_flags", FL_NONE);
        end
        if (status != 0) return;
        if (step_mode) begin
            int p = $urandom_range(0, 3);
            for (int k = 0; k < p; k++) begin
                chk_flags("pause_hold", FL_PAUSE);
                chk("pause_req", o_req, 0);
                @(negedge clk);
            end
            chk_flags("pause", FL_PAUSE);
            if ($urandom_range(0, 3) == 0) begin
                step_mode = 0; i_step_mode = 0;
                @(negedge clk);
            end else begin
                i_step = 1;
                @(negedge clk);
                i_step = 0;
            end
        end
        chk_flags("next_fetch", FL_FETCH);
    endtask

    // Terminal states must ignore every input except reset.
    task automatic hold_terminal(input bit is_fault);
        for (int k = 0; k < 4; k++) begin
            i_start = $urandom; i_ack = $urandom; i_step = $urandom; i_mem_error = $urandom;
            i_exec_done = $urandom; i_call = $urandom; i_return = $urandom;
            i_instruction = $urandom;
            @(negedge clk);
            chk_flags("term_flags", FL_NONE);
            chk("term_req", o_req, 0);
            chk("term_fault", o_fault, is_fault);
            chk("term_done", o_all_done, !is_fault);
            if (is_fault) chk("term_code", o_fault_code, m_code);
        end
        clear_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        clear_inputs();
        i_reset = 1; i_step_mode = 0; step_mode = 0;

        // Straight-line program, end_of_code on the 4th instruction
        do_reset();
        start_seq();
        for (int i = 0; i < 4; i++) run_instr(0, 0, $urandom_range(0, 2), (i == 3), 0, 0, 0, '0, st);
        hold_terminal(0);

        // Wait states: 3, then the longest legal wait, then one too many
        do_reset();
        start_seq();
        run_instr(3, 0, 0, 0, 0, 0, 0, '0, st);
        run_instr(WL - 1, 0, 0, 0, 0, 0, 0, '0, st);
        run_instr(WL, 0, 0, 0, 0, 0, 0, '0, st);
        hold_terminal(1);

        // Call/return: jump to 5, call 0x40, return from 0x41, land on 6
        do_reset();
        start_seq();
        run_instr(0, 0, 0, 0, 0, 0, 1, 16'h0005, st);
        run_instr(1, 0, 1, 0, 0, 1, 0, 16'h0040, st);
        run_instr(0, 0, 0, 0, 0, 0, 0, '0, st);
        run_instr(2, 0, 0, 0, 1, 0, 0, 16'h1234, st);
        run_instr(0, 0, 0, 1, 0, 0, 0, '0, st);
        hold_terminal(0);

        // Overflow: STACK_DEPTH+1 nested calls
        do_reset();
        start_seq();
        for (int i = 0; i <= SD; i++) begin
            run_instr(0, 0, 0, 0, 0, 1, 0, 16'($urandom), st);
            if (st != 0) break;
        end
        hold_terminal(1);

        // Underflow: return at level 0
        do_reset();
        start_seq();
        run_instr(0, 0, 0, 0, 1, 0, 0, '0, st);
        hold_terminal(1);

        // Step mode
        do_reset();
        step_mode = 1; i_step_mode = 1;
        start_seq();
        for (int i = 0; i < 6; i++) run_instr(0, 0, 1, (i == 5), 0, 0, 0, '0, st);
        hold_terminal(0);

        // ack and mem_error together
        do_reset();
        start_seq();
        run_instr(1, 1, 0, 0, 0, 0, 0, '0, st);
        hold_terminal(1);

        // PC wrap from all-ones
        do_reset();
        start_seq();
        run_instr(0, 0, 0, 0, 0, 0, 1, 16'hFFFF, st);
        run_instr(0, 0, 0, 0, 0, 0, 0, '0, st);
        run_instr(0, 0, 0, 1, 0, 0, 0, '0, st);
        hold_terminal(0);

        // Reset in the middle of a pending fetch
        do_reset();
        start_seq();
        for (int k = 0; k < 3; k++) begin
            chk("midfetch_req", o_req, 1);
            @(negedge clk);
        end
        i_reset = 1;
        @(negedge clk);
        chk("rst_mid_req", o_req, 0);
        chk_flags("rst_mid_flags", FL_IDLE);
        i_reset = 0;
        i_ack = 1; i_instruction = 32'hDEAD_BEEF;
        @(negedge clk);
        i_ack = 0;
        chk_flags("rst_mid_idle", FL_IDLE);
        chk("rst_mid_req2", o_req, 0);
        chk("rst_mid_dreg", o_decode_reg, 0);
        m_pc = '0; m_stack.delete();
        start_seq();
        run_instr(0, 0, 0, 1, 0, 0, 0, '0, st);
        hold_terminal(0);

        // Randomized programs
        for (int run = 0; run < 8; run++) begin
            do_reset();
            step_mode = ($urandom_range(0, 2) == 0);
            i_step_mode = step_mode;
            start_seq();
            for (int n = 0; n < 25; n++) begin
                int r, w;
                bit eoc, ret, call, jmp, err;
                r = $urandom_range(0, 19);
                w = (r == 0) ? WL : (r == 1) ? WL - 1 : $urandom_range(0, 3);
                err = ($urandom_range(0, 29) == 0);
                r = $urandom_range(0, 15);
                eoc = (n == 24) || (r == 0);
                ret = (r == 1 || r == 2) || (r == 0 && $urandom_range(0, 1) == 1);
                call = (r == 3 || r == 4 || r == 5) || ((r == 1) && $urandom_range(0, 1) == 1);
                jmp = (r == 6 || r == 7) || ((r == 3) && $urandom_range(0, 1) == 1);
                run_instr(w, err, $urandom_range(0, 3), eoc, ret, call, jmp, 16'($urandom), st);
                if (st != 0) break;
            end
            if (st == 0) begin
                $display("FAIL random_run_end: program %0d did not terminate", run);
                err_cnt++;
            end else begin
                hold_terminal(st == 2);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
